motor_pwm_ctrl: RTL and testbench
=================================

MOTOR_PWM_CTRL -- requirements
Module: motor_pwm_ctrl

Parameters
REQ-001 The block SHALL have parameter CH, default 2, giving the number of independent motor channels.
REQ-002 The block SHALL have parameter CNT_W, default 19, giving the width of the carrier counter and of each duty word.
REQ-003 The block SHALL have parameter PERIOD, default 250000, giving carrier cycles per PWM period (400 Hz at 100 MHz).
REQ-004 The block SHALL have parameter DEAD_CYCLES, default 1000, giving the coast time in clocks applied before any direction reversal.
REQ-005 The block SHALL have parameter OC_FILT, default 16, giving the consecutive high samples required to declare overcurrent.

Interface
REQ-006 clk  input  1  100 MHz system clock; all logic on rising edge.
REQ-007 rst_n  input  1  synchronous, active-low reset.
REQ-008 duty_cmd  input  CH*CNT_W  per-channel requested high time in clocks; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-009 dir  input  CH  per-channel direction request: 0 forward, 1 reverse.
REQ-010 en  input  CH  per-channel run enable.
REQ-011 oc_in  input  CH  per-channel overcurrent sense, already synchronised, active high.
REQ-012 fault_clr  input  1  single-cycle request to clear latched faults.
REQ-013 pwm  output  CH  per-channel bridge enable (ENA/ENB).
REQ-014 in1, in2  output  CH each  per-channel bridge direction pins.
REQ-015 fault  output  CH  per-channel latched overcurrent flag.
REQ-016 period_start  output  1  one-clock strobe at carrier wrap.

Function
REQ-017 The shared counter cnt SHALL count 0 to PERIOD-1 and wrap to 0; period_start SHALL be high exactly in the cycle after cnt==PERIOD-1.
REQ-018 Each channel SHALL load its active duty duty_act[i] from duty_cmd[i] only when cnt==PERIOD-1, so that duty changes take effect at a period boundary with no mid-period glitch.
REQ-019 A loaded duty_cmd greater than PERIOD SHALL saturate to PERIOD.
REQ-020 pwm[i] SHALL be registered and SHALL equal (cnt < duty_act[i]) one clock later, gated by the channel state.
REQ-021 Duty 0 SHALL give a constant-low pwm; duty PERIOD SHALL give a constant-high pwm.
REQ-022 Each channel SHALL run an FSM with states IDLE, FWD, REV, DEAD and FAULT.
REQ-023 Output mapping per state SHALL be:
- IDLE, DEAD and FAULT: in1=in2=0 and pwm=0.
- FWD: in1=1, in2=0, pwm active.
- REV: in1=0, in2=1, pwm active.
REQ-024 From IDLE with en=1, the channel SHALL go to FWD if dir=0 and to REV if dir=1 on the next clock.
REQ-025 In FWD or REV, a dir value opposite the current state SHALL cause entry to DEAD and load a dead counter with DEAD_CYCLES.
REQ-026 In DEAD, the channel SHALL decrement the dead counter and, when it reaches 0, enter FWD or REV according to the current dir.
REQ-027 A dir toggle during DEAD SHALL NOT restart the dead counter.
REQ-028 en=0 in FWD, REV or DEAD SHALL force IDLE on the next clock.
REQ-029 Overcurrent filtering SHALL use a per-channel saturating counter that increments while oc_in=1 and clears to 0 while oc_in=0.
REQ-030 When the filter counter reaches OC_FILT, the channel SHALL enter FAULT from any state and fault[i] SHALL be set.
REQ-031 FAULT SHALL exit to IDLE and clear fault[i] only on fault_clr=1 while oc_in[i]=0; fault_clr while oc_in[i]=1 SHALL be ignored.
REQ-032 Transition priority each clock SHALL be: fault entry > en=0 > direction change > start.
REQ-033 Channels SHALL be fully independent; a fault on one channel SHALL NOT affect any other channel.

Reset
REQ-034 While rst_n=0 at a clock edge, the block SHALL set: cnt=0, all duty_act=0, all FSMs IDLE, filter and dead counters 0, pwm=0, in1=0, in2=0, fault=0, period_start=0.
REQ-035 Reset asserted mid-period or during DEAD or FAULT SHALL abort the operation and SHALL NOT preserve any state.

Verification
REQ-036 en[0]=1, dir[0]=0, duty 62500 -> in1[0]=1, in2[0]=0; pwm[0] high 62500 of every 250000 clocks (25%).
REQ-037 duty changed from 125000 to 187500 at cnt=1000 -> current period keeps 125000 high; next period is high 187500.
REQ-038 dir[0] toggled 0->1 while running -> in1=in2=pwm=0 for exactly 1000 clocks, then in1=0, in2=1.
REQ-039 oc_in[1] high 15 clocks then low -> no fault; oc_in[1] high 16 clocks -> fault[1]=1, pwm[1]=0, channel 0 unaffected.
REQ-040 fault_clr while oc_in[1]=1 -> fault[1] stays 1; fault_clr after oc_in[1]=0 -> fault[1]=0 and channel restarts via IDLE.
REQ-041 duty_cmd=300000 -> pwm constant high; rst_n=0 pulsed mid-period -> all outputs 0 next clock and cnt restarts at 0.

Source files
------------

// File: rtl/motor_pwm_ctrl.sv
// Multi-channel H-bridge PWM controller: shared carrier, boundary-latched duty,
// per-channel direction FSM with coast-before-reverse and filtered overcurrent trip.
module motor_pwm_ctrl #(
   parameter int CH          = 2,
   parameter int CNT_W       = 19,
   parameter int PERIOD      = 250000,
   parameter int DEAD_CYCLES = 1000,
   parameter int OC_FILT     = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CH*CNT_W-1:0] duty_cmd,
   input  logic [CH-1:0]       dir,
   input  logic [CH-1:0]       en,
   input  logic [CH-1:0]       oc_in,
   input  logic                fault_clr,
   output logic [CH-1:0]       pwm,
   output logic [CH-1:0]       in1,
   output logic [CH-1:0]       in2,
   output logic [CH-1:0]       fault,
   output logic                period_start
);

   localparam logic [CNT_W-1:0] PERIOD_W = CNT_W'(PERIOD);
   localparam logic [CNT_W-1:0] LAST_W   = CNT_W'(PERIOD - 1);
   localparam int DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES + 1) : 1;
   localparam int OC_W   = (OC_FILT > 1) ? $clog2(OC_FILT + 1) : 1;
   localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYCLES);
   localparam logic [DEAD_W-1:0] DEAD_ONE  = DEAD_W'(1);
   localparam logic [OC_W-1:0]   OC_TRIP   = OC_W'(OC_FILT);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FWD   = 3'd1,
      S_REV   = 3'd2,
      S_DEAD  = 3'd3,
      S_FAULT = 3'd4
   } state_t;

   function automatic logic [CNT_W-1:0] sat_duty(input logic [CNT_W-1:0] d);
      return (d > PERIOD_W) ? PERIOD_W : d;
   endfunction

   logic [CNT_W-1:0] cnt_p0;
   logic             wrap_p0;

   assign wrap_p0 = (cnt_p0 == LAST_W);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_p0       <= '0;
         period_start <= 1'b0;
      end else begin
         cnt_p0       <= wrap_p0 ? '0 : cnt_p0 + 1'b1;
         period_start <= wrap_p0;
      end
   end

   for (genvar i = 0; i < CH; i++) begin : g_ch
      state_t              state_q;
      state_t              state_d;
      logic [CNT_W-1:0]    duty_act;
      logic [DEAD_W-1:0]   dead_cnt;
      logic [OC_W-1:0]     oc_cnt;
      logic                oc_trip;
      logic                run_d;
      logic                pwm_p1;
      logic                in1_s;
      logic                in2_s;
      logic                flt_s;

      assign oc_trip = (oc_cnt == OC_TRIP);
      assign run_d   = (state_d == S_FWD) || (state_d == S_REV);

      // Duty only changes at the wrap so a period is never cut short or stretched.
      always_ff @(posedge clk) begin
         if (!rst_n)
            duty_act <= '0;
         else if (wrap_p0)
            duty_act <= sat_duty(duty_cmd[i*CNT_W +: CNT_W]);
      end

      always_ff @(posedge clk) begin
         if (!rst_n)
            oc_cnt <= '0;
         else if (!oc_in[i])
            oc_cnt <= '0;
         else if (!oc_trip)
            oc_cnt <= oc_cnt + 1'b1;
      end

      // Counter is loaded only on entry to DEAD, so dir chatter cannot extend the coast.
      always_ff @(posedge clk) begin
         if (!rst_n)
            dead_cnt <= '0;
         else if ((state_d == S_DEAD) && (state_q != S_DEAD))
            dead_cnt <= DEAD_LOAD;
         else if ((state_q == S_DEAD) && (dead_cnt != '0))
            dead_cnt <= dead_cnt - 1'b1;
      end

      always_ff @(posedge clk) begin
         if (!rst_n)
            state_q <= S_IDLE;
         else
            state_q <= state_d;
      end

      always_comb begin
         state_d = state_q;
         if (oc_trip) begin
            state_d = S_FAULT;
         end else begin
            case (state_q)
               S_IDLE:  if (en[i]) state_d = dir[i] ? S_REV : S_FWD;
               S_FWD: begin
                  if (!en[i])      state_d = S_IDLE;
                  else if (dir[i]) state_d = S_DEAD;
               end
               S_REV: begin
                  if (!en[i])       state_d = S_IDLE;
                  else if (!dir[i]) state_d = S_DEAD;
               end
               S_DEAD: begin
                  if (!en[i])                 state_d = S_IDLE;
                  else if (dead_cnt <= DEAD_ONE) state_d = dir[i] ? S_REV : S_FWD;
               end
               S_FAULT: if (fault_clr && !oc_in[i]) state_d = S_IDLE;
               default: state_d = S_IDLE;
            endcase
         end
      end

      always_comb begin
         in1_s = 1'b0;
         in2_s = 1'b0;
         flt_s = 1'b0;
         case (state_q)
            S_FWD:   in1_s = 1'b1;
            S_REV:   in2_s = 1'b1;
            S_FAULT: flt_s = 1'b1;
            default: ;
         endcase
      end

      // Stage p1: gating by the next state keeps pwm aligned with in1/in2 after the edge.
      always_ff @(posedge clk) begin
         if (!rst_n)
            pwm_p1 <= 1'b0;
         else
            pwm_p1 <= run_d && (cnt_p0 < duty_act);
      end

      assign pwm[i]   = pwm_p1;
      assign in1[i]   = in1_s;
      assign in2[i]   = in2_s;
      assign fault[i] = flt_s;
   end

endmodule

// File: tb/tb_motor_pwm_ctrl.sv
// Directed bench for motor_pwm_ctrl on a scaled carrier (PERIOD=100, DEAD_CYCLES=10),
// expected values worked out by hand from the carrier and FSM timing.
module tb_motor_pwm_ctrl;

   localparam int CH          = 2;
   localparam int CNT_W       = 9;
   localparam int PERIOD      = 100;
   localparam int DEAD_CYCLES = 10;
   localparam int OC_FILT     = 16;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [CH*CNT_W-1:0] duty_cmd;
   logic [CH-1:0]       dir;
   logic [CH-1:0]       en;
   logic [CH-1:0]       oc_in;
   logic                fault_clr;
   logic [CH-1:0]       pwm;
   logic [CH-1:0]       in1;
   logic [CH-1:0]       in2;
   logic [CH-1:0]       fault;
   logic                period_start;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   motor_pwm_ctrl #(
      .CH(CH), .CNT_W(CNT_W), .PERIOD(PERIOD),
      .DEAD_CYCLES(DEAD_CYCLES), .OC_FILT(OC_FILT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .duty_cmd(duty_cmd), .dir(dir), .en(en),
      .oc_in(oc_in), .fault_clr(fault_clr), .pwm(pwm), .in1(in1), .in2(in2),
      .fault(fault), .period_start(period_start)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_duty(input int ch, input int d);
      duty_cmd[ch*CNT_W +: CNT_W] = CNT_W'(d);
   endtask

   task automatic count_high(input int ch, input int n, output int hi, output int ps);
      hi = 0;
      ps = 0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         hi += int'(pwm[ch]);
         ps += int'(period_start);
      end
   endtask

   task automatic wait_ps(input string tag);
      int t;
      t = 0;
      while (period_start !== 1'b1 && t < 3*PERIOD) begin
         @(negedge clk);
         t++;
      end
      chk(tag, period_start, 1);
   endtask

   task automatic measure(input int ch, input string tag, input int exp);
      int hi, ps;
      wait_ps({tag, "_sync"});
      count_high(ch, PERIOD, hi, ps);
      chk(tag, hi, exp);
   endtask

   initial begin
      int n, a, b, c, ps, hi;
      logic pwm_seen;

      rst_n = 1'b0; duty_cmd = '0; dir = '0; en = '0; oc_in = '0; fault_clr = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_pwm", pwm, 0);
      chk("rst_in1", in1, 0);
      chk("rst_in2", in2, 0);
      chk("rst_fault", fault, 0);
      chk("rst_ps", period_start, 0);

      // channel 0 forward at 25 %
      set_duty(0, 25);
      en[0] = 1'b1;
      rst_n = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (period_start !== 1'b1 && n < 3*PERIOD);
      chk("first_wrap", n, PERIOD);
      chk("fwd_in1", in1[0], 1);
      chk("fwd_in2", in2[0], 0);
      measure(0, "duty25", 25);

      // duty change mid-period takes effect at the next boundary
      count_high(0, 10, a, ps);
      set_duty(0, 75);
      count_high(0, PERIOD-10, b, ps);
      chk("keep_old", a + b, 25);
      count_high(0, PERIOD, c, ps);
      chk("new_duty", c, 75);
      chk("ps_once", ps, 1);

      // reversal with dir chatter during the coast
      dir[0] = 1'b1;
      @(negedge clk);
      n = 0;
      pwm_seen = 1'b0;
      while (in1[0] === 1'b0 && in2[0] === 1'b0 && n < 5*DEAD_CYCLES) begin
         n++;
         pwm_seen |= pwm[0];
         if (n == 3) dir[0] = 1'b0;
         if (n == 5) dir[0] = 1'b1;
         @(negedge clk);
      end
      chk("dead_len", n, DEAD_CYCLES);
      chk("dead_pwm", pwm_seen, 0);
      chk("rev_in1", in1[0], 0);
      chk("rev_in2", in2[0], 1);
      measure(0, "rev_duty", 75);

      // overcurrent filter on channel 1
      set_duty(1, 50);
      en[1] = 1'b1;
      repeat (2) @(negedge clk);
      chk("ch1_fwd", in1[1], 1);
      oc_in[1] = 1'b1;
      repeat (OC_FILT-1) @(negedge clk);
      oc_in[1] = 1'b0;
      repeat (4) @(negedge clk);
      chk("oc15_nofault", fault[1], 0);
      chk("oc15_run", in1[1], 1);
      oc_in[1] = 1'b1;
      repeat (OC_FILT) @(negedge clk);
      oc_in[1] = 1'b0;
      repeat (2) @(negedge clk);
      chk("oc16_fault", fault[1], 1);
      chk("oc16_pwm", pwm[1], 0);
      chk("oc16_in1", in1[1], 0);
      chk("ch0_nofault", fault[0], 0);
      chk("ch0_in2", in2[0], 1);
      measure(0, "ch0_indep", 75);

      // fault clear only honoured with oc low
      oc_in[1] = 1'b1;
      @(negedge clk);
      fault_clr = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0;
      @(negedge clk);
      chk("clr_ignored", fault[1], 1);
      oc_in[1] = 1'b0;
      repeat (2) @(negedge clk);
      fault_clr = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0;
      chk("clr_fault", fault[1], 0);
      chk("clr_idle_in1", in1[1], 0);
      @(negedge clk);
      chk("restart_in1", in1[1], 1);
      measure(1, "ch1_duty", 50);

      // duty 0 and saturation
      set_duty(0, 0);
      measure(0, "d0_prev", 75);
      measure(0, "duty_zero", 0);
      set_duty(0, 300);
      measure(0, "zero_tail", 0);
      measure(0, "duty_sat", 100);

      // reset mid-period with channel 1 faulted
      oc_in[1] = 1'b1;
      repeat (20) @(negedge clk);
      chk("refault", fault[1], 1);
      oc_in[1] = 1'b0;
      repeat (10) @(negedge clk);
      chk("sat_high_mid", pwm[0], 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mrst_pwm", pwm, 0);
      chk("mrst_in1", in1, 0);
      chk("mrst_in2", in2, 0);
      chk("mrst_fault", fault, 0);
      chk("mrst_ps", period_start, 0);
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      hi = 0;
      do begin
         @(negedge clk);
         n++;
         hi += int'(pwm[0]);
      end while (period_start !== 1'b1 && n < 3*PERIOD);
      chk("rst_wrap", n, PERIOD);
      chk("rst_duty_cleared", hi, 0);
      chk("rst_rev_in2", in2[0], 1);
      measure(0, "post_rst", 100);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
